// File: rtl/ps2_keyboard_if.sv
// CPU-side keyboard window: read strobe, decode hit and the returned status/data word.
interface ps2_keyboard_if;
    logic        sel;
    logic        rd;
    logic [31:0] dout;

    modport master (output sel, output rd, input dout);
    modport slave  (input sel, input rd, output dout);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: pin synchroniser, frame deserialiser with timeout,
// and a scan-code FIFO popped by CPU loads from the keyboard window.
module ps2_keyboard #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ps2_clk,
    input  logic           ps2_dat,
    ps2_keyboard_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

    // Two-flop synchronisers (idle-high) plus edge register on the clock line
    logic clk_s1, clk_sync, clk_prev;
    logic dat_s1, dat_sync;
    logic fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_sync <= clk_s1;
            clk_prev <= clk_sync;
            dat_s1   <= ps2_dat;
            dat_sync <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    rx_state_t       state_q, state_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic [9:0]      shifted;
    logic            push_c;
    logic            frame_err_set_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= 4'd0;
            shift_q   <= 10'd0;
            timeout_q <= TW'(0);
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            timeout_q <= timeout_d;
        end
    end

    // Frame bits arrive LSB first; after ten shifts: [7:0] data, [8] parity, [9] stop
    always_comb begin
        state_d         = state_q;
        bitcnt_d        = bitcnt_q;
        shift_d         = shift_q;
        timeout_d       = timeout_q;
        push_c          = 1'b0;
        frame_err_set_c = 1'b0;
        shifted         = {dat_sync, shift_q[9:1]};

        case (state_q)
            IDLE: begin
                if (fall && !dat_sync) begin
                    state_d   = SHIFT;
                    bitcnt_d  = 4'd0;
                    timeout_d = TW'(0);
                end
            end
            SHIFT: begin
                if (fall) begin
                    shift_d   = shifted;
                    timeout_d = TW'(0);
                    if (bitcnt_q == 4'd9) begin
                        state_d  = IDLE;
                        bitcnt_d = 4'd0;
                        if (shifted[9] && (^shifted[8:0]))
                            push_c = 1'b1;
                        else
                            frame_err_set_c = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d         = IDLE;
                    bitcnt_d        = 4'd0;
                    timeout_d       = TW'(0);
                    shift_d         = 10'd0;
                    frame_err_set_c = 1'b1;
                end else begin
                    timeout_d = timeout_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan-code FIFO with one extra pointer bit to tell full from empty
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full;
    logic        rd_hit, pop, push_ok, ovf_set;
    logic        overflow_q, frame_err_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_hit  = bus.sel & bus.rd;
    assign pop     = rd_hit & ~empty;
    assign push_ok = push_c & (~full | pop);
    assign ovf_set = push_c & full & ~pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= (AW + 1)'(0);
            rd_ptr_q <= (AW + 1)'(0);
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr_q[AW-1:0]] <= shifted[7:0];
                wr_ptr_q              <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Sticky flags: a set event in the same cycle as a clearing read wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ovf_set)     overflow_q <= 1'b1;
            else if (rd_hit) overflow_q <= 1'b0;
            if (frame_err_set_c) frame_err_q <= 1'b1;
            else if (rd_hit)     frame_err_q <= 1'b0;
        end
    end

    assign bus.dout = {21'd0, frame_err_q, overflow_q, ~empty,
                       empty ? 8'd0 : mem[rd_ptr_q[AW-1:0]]};

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: framing, parity/timeout errors, FIFO overflow and pop timing.
module tb_ps2_keyboard;
    localparam int HALF = 10;

    logic clock;
    logic reset;
    logic ps2_clk;
    logic ps2_dat;
    int   tests_run;
    int   tests_failed;

    ps2_keyboard_if bus ();

    ps2_keyboard #(.DEPTH(8), .TIMEOUT_CYCLES(20000)) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: plain bit; 1: check push latency around this falling edge; 2: CPU pop coincides with fall
    task automatic ps2_bit(input logic b, input int mode, input logic [31:0] exp);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            tick(2);
            check("lat_pre", {31'd0, bus.dout[8]}, 32'd0);
            tick(1);
            check("lat_post", bus.dout, exp);
            tick(HALF - 3);
        end else if (mode == 2) begin
            tick(2);
            bus.sel = 1'b1;
            bus.rd  = 1'b1;
            tick(1);
            bus.sel = 1'b0;
            bus.rd  = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input int mode,
                              input logic [31:0] exp);
        logic par;
        par = ~(^d) ^ flip;
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 0, 0);
        ps2_bit(par, 0, 0);
        ps2_bit(1'b1, mode, exp);
        ps2_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i], 0, 0);
        ps2_dat = 1'b1;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        check(tag, bus.dout, exp);
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
        tick(1);
        bus.sel = 1'b0;
        bus.rd  = 1'b0;
    endtask

    initial begin
        clock        = 1'b0;
        reset        = 1'b1;
        ps2_clk      = 1'b1;
        ps2_dat      = 1'b1;
        bus.sel      = 1'b0;
        bus.rd       = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        tick(3);
        check("reset_init", bus.dout, 32'd0);
        reset = 1'b0;
        tick(2);

        // Reset mid-frame discards the partial bits
        send_partial(8'h1C, 4);
        reset = 1'b1;
        tick(1);
        check("rst_during", bus.dout, 32'd0);
        reset = 1'b0;
        tick(1);
        check("rst_after", bus.dout, 32'd0);
        send_frame(8'h1C, 1'b0, 0, 0);
        check("rst_frame", bus.dout, 32'h0000_011C);
        pop("rst_pop", 32'h0000_011C);
        check("rst_empty", bus.dout, 32'd0);

        // Single byte with exact push-visibility latency
        send_frame(8'h1C, 1'b0, 1, 32'h0000_011C);
        pop("single_pop", 32'h0000_011C);
        check("single_empty", bus.dout, 32'd0);

        // Parity error
        send_frame(8'h1C, 1'b1, 0, 0);
        check("par_err", bus.dout, 32'h0000_0400);
        pop("par_rd", 32'h0000_0400);
        check("par_clear", bus.dout, 32'd0);

        // Overflow: nine bytes into eight entries
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0, 0);
        check("ovf_state", bus.dout, 32'h0000_0301);
        for (int k = 1; k <= 8; k++)
            pop($sformatf("ovf_pop%0d", k), (k == 1) ? 32'h0000_0301 : (32'h100 | 32'(k)));
        pop("ovf_pop9", 32'd0);
        check("ovf_empty", bus.dout, 32'd0);

        // Timeout mid-frame, then a clean frame
        send_partial(8'hFF, 3);
        tick(19980);
        check("to_pre", bus.dout, 32'd0);
        tick(40);
        check("to_err", bus.dout, 32'h0000_0400);
        send_frame(8'hF0, 1'b0, 0, 0);
        check("to_f0", bus.dout & 32'h1FF, 32'h0000_01F0);

        // Strobes on their own have no side effects
        bus.sel = 1'b1;
        tick(1);
        bus.sel = 1'b0;
        check("sel_only", bus.dout, 32'h0000_05F0);
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        check("rd_only", bus.dout, 32'h0000_05F0);
        pop("to_pop", 32'h0000_05F0);
        check("to_empty", bus.dout, 32'd0);

        // Push into a full FIFO coinciding with a pop
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 0, 0);
        check("sim_full", bus.dout, 32'h0000_0101);
        send_frame(8'h09, 1'b0, 2, 0);
        check("sim_head", bus.dout, 32'h0000_0102);
        for (int k = 2; k <= 9; k++)
            pop($sformatf("sim_pop%0d", k), 32'h100 | 32'(k));
        check("sim_empty", bus.dout, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver with a scan-code FIFO. It provides the `dout_kbd` word for the MMIO keyboard window. The block samples the asynchronous `ps2_clk`/`ps2_dat` pins, deframes 11-bit PS/2 device-to-host frames and checks them. Valid scan codes are buffered until the CPU pops them with a load from the keyboard address.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, 20000: idle `clock` cycles allowed mid-frame before the receiver aborts the frame. This is 2 ms at 10 MHz.

Ports:
- `clock`  in  1: system clock, the only clock. All state changes on rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous.
- `ps2_dat`  in  1: raw PS/2 data pin, asynchronous.
- `sel`  in  1: MMU decode hit for the keyboard window.
- `rd`  in  1: load strobe. `sel & rd` for one cycle equals one CPU read.
- `dout`  out  32: read word, combinational from registered state.
  - `[7:0]` head scan code (0 when empty).
  - `[8]` nonempty.
  - `[9]` overflow, sticky.
  - `[10]` frame error, sticky.
  - `[31:11]` always 0.

## Operation
- Input sync: `ps2_clk` and `ps2_dat` each pass through 2 flops, reset value 1. A third flop on the clock line (`clk_prev`) gives `fall = clk_prev & ~clk_sync`.
- Receiver FSM, states IDLE and SHIFT. It uses a 4-bit `bitcnt` and a 10-bit shift register.
  - IDLE, on `fall`:
    - If `dat_sync == 0` (start bit): go to SHIFT, `bitcnt = 0`, clear the timeout counter.
    - If `dat_sync == 1`: stay in IDLE. This is not an error.
  - SHIFT, on `fall`: shift `dat_sync` in (LSB-first data), `bitcnt++`, clear the timeout counter.
  - Frame end: the 10th shift in SHIFT (8 data, parity, stop) ends the frame and returns to IDLE.
    - Valid when stop == 1 and the XOR of the 8 data bits and parity == 1 (odd parity). A valid frame pushes the data byte.
    - Otherwise the frame is dropped and `frame_err` is set.
  - Timeout: in SHIFT, the counter increments each cycle without `fall`. Reaching `TIMEOUT_CYCLES` returns to IDLE, discards partial data and sets `frame_err`.
- FIFO: circular buffer with `DEPTH` entries and read/write pointers one bit wider than the index, for full/empty detection.
  - Push when full: byte dropped, `overflow` set. FIFO contents unchanged.
  - Pop happens when `sel & rd & nonempty`: the head pointer advances.
  - Push and pop in the same cycle: both happen. When full, the push is accepted and `overflow` is not set. When empty, there is no pop, only the push.
- Sticky flags: `overflow` and `frame_err` clear on any `sel & rd`, whether or not the FIFO is empty. The read that clears them still returns them as 1.
  - If a set event and a clearing read occur in the same cycle, the set wins.
- `sel` without `rd`, or `rd` without `sel`: no side effects.

## Timing
- Reset:
  - FSM in IDLE, `bitcnt = 0`, timeout counter 0.
  - Pointers equal (empty), flags 0, sync flops 1.
  - `dout = 0` throughout reset and on the first cycle after it.
- Pin to `fall` latency: 3 clock edges after the pin's falling transition, because of the 2-flop sync plus the edge register.
- Push to visibility: the stop-bit `fall` cycle writes the FIFO. `dout[8]` and `dout[7:0]` reflect the byte from the next cycle.
- Pop: `dout` shows the head during the `sel & rd` cycle (the CPU samples it then). The next head, or 0 and `nonempty = 0`, shows from the following cycle.
- Reset mid-frame: the partial frame is discarded. The next valid start bit is received normally.
- Back-to-back pops on consecutive cycles are supported, one entry per cycle.
- PS/2 clocks are 10–16.7 kHz; `clock` ≥ 1 MHz is required.

## Test plan
- Reset behaviour: assert `reset` mid-SHIFT, after 5 bits of 0x1C → `dout == 0`. Then send a full 0x1C frame → `dout == 0x0000011C`.
- Single byte: send 0x1C (bits 0,00111000,parity 0,stop 1) → 1 cycle after the stop-bit `fall`, `dout == 0x11C`. Pulse `sel & rd` → next cycle `dout == 0`.
- Parity error: send 0x1C with parity 1 → FIFO stays empty, `dout == 0x400`. One read → next cycle `dout == 0`.
- Overflow: send 9 bytes 0x01..0x09 with `DEPTH = 8`, no reads → `dout == 0x301`. 8 pops return 0x01..0x08; the 9th read shows `dout == 0`.
- Timeout: send start bit plus 3 data bits, then hold `ps2_clk = 1` for 20000 cycles → `frame_err` set, FSM in IDLE. A following full 0xF0 frame → `dout[8:0] == 0x1F0`.
- Simultaneous push/pop: FIFO full with 8 bytes; the 9th byte's stop-bit `fall` coincides with `sel & rd` → `overflow` stays 0, 8 entries remain, and the last pop returns the 9th byte.
